// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clock period / duty-cycle measurement block.
package clk_div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

    function automatic int cnt_width(input int max_div);
        return $clog2(max_div + 1);
    endfunction

endpackage

// File: rtl/sync_rise.sv
// Multi-flop synchronizer for an asynchronous input, plus one extra flop
// used to detect the synchronized rising edge.
module sync_rise #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q_sync,
    output logic rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_d;

    // Shift the raw input through the synchronizer chain, then delay once more
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync   <= '0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], d};
            r_sync_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign q_sync = r_sync[SYNC_STAGES-1];
    assign rise   = r_sync[SYNC_STAGES-1] & ~r_sync_d;

endmodule

// File: rtl/clk_div_meas.sv
// Measures period and high time of an asynchronous clock in clk cycles,
// reports lock after repeated identical measurements and times out on a stalled input.
module clk_div_meas
    import clk_div_pkg::*;
#(
    parameter int MAX_DIV     = 256,
    parameter int LOCK_CNT    = 4,
    parameter int SYNC_STAGES = 2,
    localparam int W          = cnt_width(MAX_DIV)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clk_in,
    output logic [W-1:0] period,
    output logic [W-1:0] high_time,
    output logic         meas_valid,
    output logic         locked,
    output logic         timeout
);

    localparam int              MW        = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
    localparam logic [MW-1:0]   MATCH_MAX = MW'(LOCK_CNT - 1);
    localparam logic [W-1:0]    CNT_MAX   = W'(MAX_DIV);

    logic          w_sync;
    logic          w_rise;
    logic          w_same;
    logic [MW-1:0] w_match_next;

    state_t        r_state;
    logic [W-1:0]  r_cnt;
    logic [W-1:0]  r_hcnt;
    logic [MW-1:0] r_match;

    sync_rise #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_rise (
        .clk    (clk),
        .reset  (reset),
        .d      (clk_in),
        .q_sync (w_sync),
        .rise   (w_rise)
    );

    // Compare the finishing measurement with the one currently on the outputs
    always_comb begin
        w_same       = (r_cnt == period) && (r_hcnt == high_time);
        w_match_next = '0;
        if (!w_same) begin
            w_match_next = '0;
        end else if (r_match == MATCH_MAX) begin
            w_match_next = r_match;
        end else begin
            w_match_next = r_match + MW'(1);
        end
    end

    // Measurement state machine; every output is a flop updated here
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_hcnt     <= '0;
            r_match    <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    // First edge only opens a window; there is nothing to report yet
                    if (w_rise) begin
                        r_state <= MEAS;
                        r_cnt   <= W'(1);
                        r_hcnt  <= W'(1);
                        timeout <= 1'b0;
                    end
                end
                MEAS: begin
                    if (w_rise) begin
                        period     <= r_cnt;
                        high_time  <= r_hcnt;
                        meas_valid <= 1'b1;
                        r_match    <= w_match_next;
                        locked     <= (w_match_next == MATCH_MAX);
                        r_cnt      <= W'(1);
                        r_hcnt     <= W'(1);
                    end else if (r_cnt == CNT_MAX) begin
                        timeout <= 1'b1;
                        locked  <= 1'b0;
                        r_match <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + W'(1);
                        if (w_sync) begin
                            r_hcnt <= r_hcnt + W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_meas.sv
// Scoreboard bench: a cycle model of the measured waveform predicts each measurement.
module tb_clk_div_meas;

    localparam int MAX_DIV  = 16;
    localparam int LOCK_CNT = 4;
    localparam int SYNC     = 2;
    localparam int W        = $clog2(MAX_DIV + 1);
    localparam int TO_LAT   = SYNC + 1 + MAX_DIV;

    typedef struct packed {
        logic [W-1:0] p;
        logic [W-1:0] h;
        logic         lk;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         clk_in;
    logic [W-1:0] period, high_time;
    logic         meas_valid, locked, timeout;
    logic [W-1:0] period1, high_time1;
    logic         meas_valid1, locked1, timeout1;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t e_m;

    int m_cnt, m_hcnt, last_p, last_h, m_match;
    bit m_run, m_prev_v;

    clk_div_meas #(.MAX_DIV(MAX_DIV), .LOCK_CNT(LOCK_CNT), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .clk_in(clk_in), .period(period), .high_time(high_time),
        .meas_valid(meas_valid), .locked(locked), .timeout(timeout)
    );

    clk_div_meas #(.MAX_DIV(MAX_DIV), .LOCK_CNT(1), .SYNC_STAGES(SYNC)) dut1 (
        .clk(clk), .reset(reset), .clk_in(clk_in), .period(period1), .high_time(high_time1),
        .meas_valid(meas_valid1), .locked(locked1), .timeout(timeout1)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_run = 1'b0; m_prev_v = 1'b0; last_p = 0; last_h = 0; m_match = 0; m_cnt = 0; m_hcnt = 0;
        sb.delete();
    endtask

    // Drive one clk cycle of clk_in and advance the reference model
    task automatic step(input logic v);
        exp_t e;
        @(negedge clk);
        clk_in = v;
        if (v && !m_prev_v) begin
            if (m_run) begin
                if (m_cnt == last_p && m_hcnt == last_h)
                    m_match = (m_match < LOCK_CNT - 1) ? m_match + 1 : m_match;
                else
                    m_match = 0;
                e.p = W'(m_cnt); e.h = W'(m_hcnt); e.lk = (m_match == LOCK_CNT - 1);
                sb.push_back(e);
                last_p = m_cnt; last_h = m_hcnt;
            end
            m_run = 1'b1; m_cnt = 1; m_hcnt = 1;
        end else if (m_run) begin
            if (m_cnt == MAX_DIV) begin
                m_run = 1'b0; m_match = 0;
            end else begin
                m_cnt++;
                if (v) m_hcnt++;
            end
        end
        m_prev_v = v;
    endtask

    task automatic drive_periods(input int h, input int l, input int n);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < h + l; c++) step(c < h);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) begin
            if (sb.size() == 0) break;
            step(1'b0);
        end
    endtask

    // Scoreboard: every meas_valid pulse must match the oldest predicted measurement
    always @(negedge clk) begin
        if (reset === 1'b0 && meas_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_valid: meas_valid=1 period=%0d with no measurement expected", period);
            end else begin
                e_m = sb.pop_front();
                checks++;
                if (period !== e_m.p) begin
                    errors++; $display("FAIL sb_period: got %0d expected %0d", period, e_m.p);
                end
                checks++;
                if (high_time !== e_m.h) begin
                    errors++; $display("FAIL sb_high_time: got %0d expected %0d", high_time, e_m.h);
                end
                checks++;
                if (locked !== e_m.lk) begin
                    errors++; $display("FAIL sb_locked: got %0b expected %0b (period %0d)", locked, e_m.lk, e_m.p);
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1; clk_in = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({period, high_time, meas_valid, locked, timeout, locked1, timeout1} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: period=%0d high=%0d v=%0b lk=%0b to=%0b lk1=%0b to1=%0b, expected all 0",
                     period, high_time, meas_valid, locked, timeout, locked1, timeout1);
        end
        reset = 1'b0;
    endtask

    task automatic test_div4();
        drive_periods(2, 2, 6);
        drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL div4_drain: %0d pending, expected 0", sb.size()); end
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL div4_locked: got %0b expected 1", locked); end
    endtask

    task automatic test_div5();
        drive_periods(2, 3, 6);
        drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL div5_drain: %0d pending, expected 0", sb.size()); end
        checks++;
        if (period !== W'(5) || high_time !== W'(2)) begin
            errors++; $display("FAIL div5_last: got %0d/%0d expected 5/2", period, high_time);
        end
    endtask

    task automatic test_switch();
        drive_periods(2, 2, 6);
        drive_periods(3, 3, 6);
        drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL switch_drain: %0d pending, expected 0", sb.size()); end
        checks++;
        if (locked !== 1'b1 || period !== W'(6)) begin
            errors++; $display("FAIL switch_relock: got lk=%0b period=%0d expected 1/6", locked, period);
        end
    endtask

    task automatic test_timeout();
        drive_periods(2, 2, 5);
        step(1'b1);
        for (int k = 1; k <= TO_LAT + 2; k++) begin
            step(k == 1);
            if (k == TO_LAT - 1) begin
                checks++;
                if (timeout !== 1'b0 || locked !== 1'b1) begin
                    errors++; $display("FAIL timeout_early: got to=%0b lk=%0b expected 0/1", timeout, locked);
                end
            end
            if (k == TO_LAT) begin
                checks++;
                if (timeout !== 1'b1 || locked !== 1'b0 || period !== W'(4)) begin
                    errors++;
                    $display("FAIL timeout_hit: got to=%0b lk=%0b period=%0d expected 1/0/4", timeout, locked, period);
                end
            end
        end
        step(1'b1);
        for (int j = 1; j <= 6; j++) begin
            step(j < 2);
            if (j == SYNC) begin
                checks++;
                if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_hold: got %0b expected 1", timeout); end
            end
            if (j == SYNC + 1) begin
                checks++;
                if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %0b expected 0", timeout); end
            end
        end
        drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL timeout_drain: %0d pending, expected 0", sb.size()); end
    endtask

    task automatic test_reset_mid();
        drive_periods(4, 4, 6);
        repeat (4) step(1'b1);
        repeat (2) step(1'b0);
        reset = 1'b1;
        model_reset();
        repeat (2) step(1'b0);
        checks++;
        if ({period, high_time, meas_valid, locked, timeout} !== '0) begin
            errors++;
            $display("FAIL reset_mid: period=%0d high=%0d v=%0b lk=%0b to=%0b, expected all 0",
                     period, high_time, meas_valid, locked, timeout);
        end
        reset = 1'b0;
        repeat (2) step(1'b0);
        drive_periods(4, 4, 3);
        drain();
        checks++;
        if (sb.size() != 0 || period !== W'(8) || high_time !== W'(4)) begin
            errors++;
            $display("FAIL reset_mid_resume: pending=%0d period=%0d high=%0d expected 0/8/4", sb.size(), period, high_time);
        end
    endtask

    task automatic test_lock1();
        bit seen = 1'b0;
        repeat (MAX_DIV + 6) step(1'b0);
        checks++;
        if (timeout !== 1'b1 || timeout1 !== 1'b1) begin
            errors++; $display("FAIL lock1_idle: got to=%0b to1=%0b expected 1/1", timeout, timeout1);
        end
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 3; c++) begin
                step(c < 2);
                if (!seen && meas_valid1 === 1'b1) begin
                    seen = 1'b1;
                    checks++;
                    if (locked1 !== 1'b1 || period1 !== W'(3) || high_time1 !== W'(2)) begin
                        errors++;
                        $display("FAIL lock1_first: got lk=%0b period=%0d high=%0d expected 1/3/2",
                                 locked1, period1, high_time1);
                    end
                end
            end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL lock1_seen: got no meas_valid, expected one"); end
        drain();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL lock1_drain: %0d pending, expected 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_div4();
        test_div5();
        test_switch();
        test_timeout();
        test_reset_mid();
        test_lock1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
